// File: rtl/tdc_stat_pkg.sv
// Shared definitions for the TDC statistics readout path: record layout,
// stream tags and the readout FSM encoding.
package tdc_stat_pkg;

    // Field widths inside one statistics record.
    localparam int CNT_W  = 14;
    localparam int MEAN_W = 16;
    localparam int MSD_W  = 26;
    localparam int EDGE_W = 9;

    // Record width on the RAM port and the part of it that carries data.
    localparam int REC_W      = 160;
    localparam int REC_USED_W = 158;

    // Bit offsets of each field inside the record.
    localparam int OFF_COUNT    = 0;
    localparam int OFF_TOA_MEAN = 14;
    localparam int OFF_TOA_MSD  = 30;
    localparam int OFF_CAL_MEAN = 56;
    localparam int OFF_CAL_MSD  = 72;
    localparam int OFF_TOT_MEAN = 98;
    localparam int OFF_TOT_MSD  = 114;
    localparam int OFF_E1A      = 140;
    localparam int OFF_E2A      = 149;

    // Frame delimiters placed in the top byte of header and trailer.
    localparam logic [7:0] HDR_TAG = 8'hA5;
    localparam logic [7:0] TRL_TAG = 8'h5A;

    localparam int WORDS_PER_PIXEL = 6;

    // Readout FSM encoding, also exported on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_LOAD    = 3'd4,
        ST_EMIT    = 3'd5,
        ST_TRAILER = 3'd6
    } tdc_state_e;

endpackage

// File: rtl/tdc_stat_word_mux.sv
// Combinational selection of one 32-bit stream word out of a held pixel
// record. Word 0 carries the pixel ID, word 5 the second edge count.
module tdc_stat_word_mux
    import tdc_stat_pkg::*;
(
    input  logic [REC_USED_W-1:0] hold_i,
    input  logic [7:0]            pixel_id_i,
    input  logic [2:0]            word_idx_i,
    output logic [31:0]           word_o
);

    logic [CNT_W-1:0]  count;
    logic [MEAN_W-1:0] toa_mean;
    logic [MSD_W-1:0]  toa_msd;
    logic [MEAN_W-1:0] cal_mean;
    logic [MSD_W-1:0]  cal_msd;
    logic [MEAN_W-1:0] tot_mean;
    logic [MSD_W-1:0]  tot_msd;
    logic [EDGE_W-1:0] e1a;
    logic [EDGE_W-1:0] e2a;

    assign count    = hold_i[OFF_COUNT    +: CNT_W];
    assign toa_mean = hold_i[OFF_TOA_MEAN +: MEAN_W];
    assign toa_msd  = hold_i[OFF_TOA_MSD  +: MSD_W];
    assign cal_mean = hold_i[OFF_CAL_MEAN +: MEAN_W];
    assign cal_msd  = hold_i[OFF_CAL_MSD  +: MSD_W];
    assign tot_mean = hold_i[OFF_TOT_MEAN +: MEAN_W];
    assign tot_msd  = hold_i[OFF_TOT_MSD  +: MSD_W];
    assign e1a      = hold_i[OFF_E1A      +: EDGE_W];
    assign e2a      = hold_i[OFF_E2A      +: EDGE_W];

    // Pack the selected word; indices 6 and 7 are never requested.
    always_comb begin
        word_o = '0;
        case (word_idx_i)
            3'd0:    word_o = {pixel_id_i, e1a, 1'b0, count};
            3'd1:    word_o = {toa_mean, cal_mean};
            3'd2:    word_o = {6'd0, toa_msd};
            3'd3:    word_o = {6'd0, cal_msd};
            3'd4:    word_o = {6'd0, tot_msd};
            3'd5:    word_o = {tot_mean, 7'd0, e2a};
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/tdc_stat_readout.sv
// Snapshot readout: on snapStart, scans the frozen statistics RAM and
// streams header, six words per (non-empty) pixel, and a trailer.
// Stream handshake: a word transfers on a rising clk edge where doutValid
// and doutReady are both high; doutValid is a function of state only, and
// dout/doutSof/doutEof stay constant while doutValid waits for doutReady.
module tdc_stat_readout
    import tdc_stat_pkg::*;
#(
    parameter int N_PIXELS   = 256,
    parameter int SKIP_EMPTY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snapStart,
    input  logic [17:0]       timeStamp,
    output logic              rdEn,
    output logic [7:0]        rdAddr,
    input  logic [REC_W-1:0]  rdData,
    output logic [31:0]       dout,
    output logic              doutValid,
    input  logic              doutReady,
    output logic              doutSof,
    output logic              doutEof,
    output logic              busy,
    output logic [7:0]        overrunCnt,
    output tdc_state_e        dbgState
);

    localparam logic [7:0] LAST_PIX  = 8'(N_PIXELS - 1);
    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_PIXEL - 1);

    tdc_state_e            state_q, state_d;
    logic [17:0]           ts_q, ts_d;
    logic [7:0]            idx_q, idx_d;
    logic [8:0]            emitted_q, emitted_d;
    logic [2:0]            word_q, word_d;
    logic [REC_USED_W-1:0] hold_q, hold_d;
    logic [7:0]            overrun_q, overrun_d;
    logic [31:0]           pix_word;

    // The two top record bits carry nothing.
    logic unused_rd_bits;
    assign unused_rd_bits = ^rdData[REC_W-1:REC_USED_W];

    tdc_stat_word_mux u_mux (
        .hold_i     (hold_q),
        .pixel_id_i (idx_q),
        .word_idx_i (word_q),
        .word_o     (pix_word)
    );

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ts_q      <= '0;
            idx_q     <= '0;
            emitted_q <= '0;
            word_q    <= '0;
            hold_q    <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            idx_q     <= idx_d;
            emitted_q <= emitted_d;
            word_q    <= word_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
        end
    end

    // Count strobes that arrive while a frame is still running, saturating.
    always_comb begin
        overrun_d = overrun_q;
        if (snapStart && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    // Next-state logic and stream outputs. The RAM answers in the cycle
    // after FETCH, so the hold register is loaded on the WAIT->LOAD edge and
    // LOAD decides on the captured count.
    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        idx_d     = idx_q;
        emitted_d = emitted_q;
        word_d    = word_q;
        hold_d    = hold_q;
        rdEn      = 1'b0;
        doutValid = 1'b0;
        doutSof   = 1'b0;
        doutEof   = 1'b0;
        dout      = '0;
        case (state_q)
            ST_IDLE: begin
                if (snapStart) begin
                    state_d   = ST_HEADER;
                    ts_d      = timeStamp;
                    idx_d     = '0;
                    emitted_d = '0;
                end
            end
            ST_HEADER: begin
                doutValid = 1'b1;
                doutSof   = 1'b1;
                dout      = {HDR_TAG, 6'd0, ts_q};
                if (doutReady) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                rdEn    = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                hold_d  = rdData[REC_USED_W-1:0];
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if ((SKIP_EMPTY != 0) && (hold_q[OFF_COUNT +: CNT_W] == '0)) begin
                    if (idx_q == LAST_PIX) begin
                        state_d = ST_TRAILER;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    word_d  = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                doutValid = 1'b1;
                dout      = pix_word;
                if (doutReady) begin
                    if (word_q == LAST_WORD) begin
                        emitted_d = emitted_q + 9'd1;
                        if (idx_q == LAST_PIX) begin
                            state_d = ST_TRAILER;
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end
            end
            ST_TRAILER: begin
                doutValid = 1'b1;
                doutEof   = 1'b1;
                dout      = {TRL_TAG, 15'd0, emitted_q};
                if (doutReady) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rdAddr     = idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrunCnt = overrun_q;
    assign dbgState   = state_q;

endmodule

// File: tb/tb_tdc_stat_readout.sv
// Directed bench for tdc_stat_readout: one instance skips empty pixels,
// a second one emits every pixel. Both read the same RAM image.
module tb_tdc_stat_readout;
    import tdc_stat_pkg::*;

    // ---------------- clock / reset / DUT signals ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         snap_a = 1'b0;
    logic         snap_b = 1'b0;
    logic [17:0]  ts = '0;
    logic         dout_ready = 1'b1;

    logic [159:0] mem [0:255];
    logic [159:0] rd_data_a = '0;
    logic [159:0] rd_data_b = '0;

    logic         rd_en_a, rd_en_b;
    logic [7:0]   rd_addr_a, rd_addr_b;
    logic [31:0]  dout_a, dout_b;
    logic         valid_a, valid_b, sof_a, sof_b, eof_a, eof_b, busy_a, busy_b;
    logic [7:0]   ovr_a, ovr_b;
    tdc_state_e   dbg_a, dbg_b;

    int total = 0;
    int bad   = 0;

    logic [31:0]  exp_q[$];
    logic [31:0]  got_a[$];
    logic [31:0]  got_b[$];
    bit           sof_a_q[$], eof_a_q[$], sof_b_q[$], eof_b_q[$];
    int           busy_cyc_a = 0;
    int           busy_cyc_b = 0;
    int           stab_viol  = 0;
    logic         pend_a = 1'b0;
    logic [33:0]  pend_val_a = '0;

    always #5 clk = ~clk;

    tdc_stat_readout #(.N_PIXELS(256), .SKIP_EMPTY(1)) dut (
        .clk(clk), .rst(rst), .snapStart(snap_a), .timeStamp(ts),
        .rdEn(rd_en_a), .rdAddr(rd_addr_a), .rdData(rd_data_a),
        .dout(dout_a), .doutValid(valid_a), .doutReady(dout_ready),
        .doutSof(sof_a), .doutEof(eof_a), .busy(busy_a),
        .overrunCnt(ovr_a), .dbgState(dbg_a)
    );

    tdc_stat_readout #(.N_PIXELS(256), .SKIP_EMPTY(0)) dut_ns (
        .clk(clk), .rst(rst), .snapStart(snap_b), .timeStamp(ts),
        .rdEn(rd_en_b), .rdAddr(rd_addr_b), .rdData(rd_data_b),
        .dout(dout_b), .doutValid(valid_b), .doutReady(dout_ready),
        .doutSof(sof_b), .doutEof(eof_b), .busy(busy_b),
        .overrunCnt(ovr_b), .dbgState(dbg_b)
    );

    // Statistics RAM: registered read, data valid the cycle after rdEn.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end

    // Stream collector, sampled mid-cycle: records transfers, busy cycles
    // and any change of a word that is waiting for ready.
    always @(negedge clk) begin
        if (rst) begin
            pend_a = 1'b0;
        end else begin
            if (pend_a && (!valid_a || {sof_a, eof_a, dout_a} !== pend_val_a)) stab_viol++;
            if (valid_a && dout_ready) begin
                got_a.push_back(dout_a); sof_a_q.push_back(sof_a); eof_a_q.push_back(eof_a);
            end
            if (valid_b && dout_ready) begin
                got_b.push_back(dout_b); sof_b_q.push_back(sof_b); eof_b_q.push_back(eof_b);
            end
            if (busy_a) busy_cyc_a++;
            if (busy_b) busy_cyc_b++;
            pend_a     = valid_a && !dout_ready;
            pend_val_a = {sof_a, eof_a, dout_a};
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [159:0] mk_rec(input logic [13:0] c, input logic [15:0] toam,
        input logic [25:0] toamsd, input logic [15:0] calm, input logic [25:0] calmsd,
        input logic [15:0] totm, input logic [25:0] totmsd, input logic [8:0] e1a,
        input logic [8:0] e2a);
        return {2'b00, e2a, e1a, totmsd, totm, calmsd, calm, toamsd, toam, c};
    endfunction

    task automatic clear_mem();
        for (int p = 0; p < 256; p++) mem[p] = '0;
    endtask

    task automatic set_sparse_mem();
        clear_mem();
        mem[0]   = mk_rec(14'd1, 16'h1111, 26'h0222222, 16'h3333, 26'h0444444,
                          16'h5555, 26'h0666666, 9'h077, 9'h088);
        mem[7]   = mk_rec(14'h0ABC, 16'hA1A1, 26'h1234567, 16'hB2B2, 26'h2345678,
                          16'hC3C3, 26'h3456789, 9'h155, 9'h0AA);
        mem[255] = mk_rec(14'd5, 16'hFFFF, 26'h3FFFFFF, 16'h0001, 26'h0000001,
                          16'h8000, 26'h2000000, 9'h100, 9'h001);
    endtask

    // Reference stream for the current RAM image.
    task automatic build_exp(input bit skip, input logic [17:0] t);
        int n = 0;
        logic [159:0] r;
        logic [7:0] pid;
        exp_q.delete();
        exp_q.push_back({8'hA5, 6'd0, t});
        for (int p = 0; p < 256; p++) begin
            r   = mem[p];
            pid = 8'(p);
            if (skip && r[13:0] == 14'd0) continue;
            exp_q.push_back({pid, r[148:140], 1'b0, r[13:0]});
            exp_q.push_back({r[29:14], r[71:56]});
            exp_q.push_back({6'd0, r[55:30]});
            exp_q.push_back({6'd0, r[97:72]});
            exp_q.push_back({6'd0, r[139:114]});
            exp_q.push_back({r[113:98], 7'd0, r[157:149]});
            n++;
        end
        exp_q.push_back({8'h5A, 15'd0, 9'(n)});
    endtask

    // Number of positions where the captured stream differs from exp_q.
    function automatic int frame_errors(input bit sel, input int base, output int first_bad);
        int errs = 0;
        first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [31:0] w;
            bit s, e, have;
            have = sel ? (base + i < got_b.size()) : (base + i < got_a.size());
            if (!have) begin
                errs++;
                if (first_bad < 0) first_bad = i;
                continue;
            end
            w = sel ? got_b[base + i]   : got_a[base + i];
            s = sel ? sof_b_q[base + i] : sof_a_q[base + i];
            e = sel ? eof_b_q[base + i] : eof_a_q[base + i];
            if (w !== exp_q[i] || s !== (i == 0) || e !== (i == exp_q.size() - 1)) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return errs;
    endfunction

    task automatic start_frame(input bit sel);
        @(posedge clk); #1;
        if (sel) snap_b = 1'b1; else snap_a = 1'b1;
        @(posedge clk); #1;
        snap_a = 1'b0;
        snap_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input int budget, output bit timeout);
        int n = 0;
        @(negedge clk);
        while ((sel ? busy_b : busy_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        timeout = sel ? busy_b : busy_a;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({valid_a, sof_a, eof_a, busy_a, rd_en_a} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl_in_rst: got %b expected 00000",
                            {valid_a, sof_a, eof_a, busy_a, rd_en_a});
        end
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (dout_a !== 32'd0) begin bad++; $display("FAIL reset_dout: got %h expected 0", dout_a); end
        total++;
        if (rd_addr_a !== 8'd0) begin bad++; $display("FAIL reset_rdaddr: got %h expected 0", rd_addr_a); end
        total++;
        if (ovr_a !== 8'd0) begin bad++; $display("FAIL reset_overrun: got %0d expected 0", ovr_a); end
        total++;
        if (dbg_a !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d expected 0", dbg_a); end
        total++;
        if ({valid_b, busy_b} !== 2'b00) begin bad++; $display("FAIL reset_ns: got %b expected 00", {valid_b, busy_b}); end
    endtask

    task automatic test_sparse();
        int base, c0, errs, fb;
        bit to;
        logic [31:0] w;
        set_sparse_mem();
        ts = 18'h00123;
        dout_ready = 1'b1;
        build_exp(1'b1, ts);
        base = got_a.size();
        c0   = busy_cyc_a;
        start_frame(1'b0);
        @(negedge clk);
        total++;
        if ({valid_a, sof_a, dout_a} !== {1'b1, 1'b1, 32'hA5000123}) begin
            bad++; $display("FAIL sparse_header_latency: got v=%b sof=%b %h expected v=1 sof=1 a5000123",
                            valid_a, sof_a, dout_a);
        end
        wait_idle(1'b0, 5000, to);
        total++;
        if (to) begin bad++; $display("FAIL sparse_timeout: busy still %b expected 0", busy_a); end
        total++;
        if (got_a.size() - base !== 20) begin
            bad++; $display("FAIL sparse_count: got %0d expected 20", got_a.size() - base);
        end
        w = got_a[base + 1];
        total++;
        if (w !== 32'h003B8001) begin bad++; $display("FAIL sparse_pix0_w0: got %h expected 003b8001", w); end
        w = got_a[base + 7];
        total++;
        if (w[31:24] !== 8'h07) begin bad++; $display("FAIL sparse_pix7_id: got %h expected 07", w[31:24]); end
        w = got_a[base + 19];
        total++;
        if (w !== 32'h5A000003) begin bad++; $display("FAIL sparse_trailer: got %h expected 5a000003", w); end
        errs = frame_errors(1'b0, base, fb);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL sparse_stream: got %0d bad words (first %0d) expected 0", errs, fb); end
        total++;
        if (busy_cyc_a - c0 !== 788) begin
            bad++; $display("FAIL sparse_busy_cycles: got %0d expected 788", busy_cyc_a - c0);
        end
    endtask

    task automatic test_field_boundaries();
        int base;
        bit to;
        logic [31:0] w;
        clear_mem();
        mem[3] = mk_rec(14'h3FFF, 16'h0, 26'h3FFFFFF, 16'h0, 26'h0, 16'h0, 26'h0, 9'h0, 9'h1FF);
        ts = 18'h2AAAA;
        base = got_a.size();
        start_frame(1'b0);
        wait_idle(1'b0, 5000, to);
        total++;
        if (to || got_a.size() - base !== 8) begin
            bad++; $display("FAIL field_count: got %0d timeout=%b expected 8", got_a.size() - base, to);
        end
        w = got_a[base];
        total++;
        if (w !== 32'hA502AAAA) begin bad++; $display("FAIL field_header: got %h expected a502aaaa", w); end
        w = got_a[base + 1];
        total++;
        if (w !== 32'h03003FFF) begin bad++; $display("FAIL field_w0: got %h expected 03003fff", w); end
        w = got_a[base + 2];
        total++;
        if (w !== 32'h00000000) begin bad++; $display("FAIL field_w1: got %h expected 00000000", w); end
        w = got_a[base + 3];
        total++;
        if (w !== 32'h03FFFFFF) begin bad++; $display("FAIL field_w2: got %h expected 03ffffff", w); end
        w = got_a[base + 6];
        total++;
        if (w !== 32'h000001FF) begin bad++; $display("FAIL field_w5: got %h expected 000001ff", w); end
        w = got_a[base + 7];
        total++;
        if (w !== 32'h5A000001) begin bad++; $display("FAIL field_trailer: got %h expected 5a000001", w); end
    endtask

    task automatic test_empty_noskip();
        int base, c0, errs, fb;
        bit to;
        logic [31:0] w;
        clear_mem();
        ts = 18'h00042;
        build_exp(1'b0, ts);
        base = got_b.size();
        c0   = busy_cyc_b;
        start_frame(1'b1);
        wait_idle(1'b1, 5000, to);
        total++;
        if (to || got_b.size() - base !== 1538) begin
            bad++; $display("FAIL noskip_count: got %0d timeout=%b expected 1538", got_b.size() - base, to);
        end
        w = got_b[base + 1537];
        total++;
        if (w !== 32'h5A000100) begin bad++; $display("FAIL noskip_trailer: got %h expected 5a000100", w); end
        errs = frame_errors(1'b1, base, fb);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL noskip_stream: got %0d bad words (first %0d) expected 0", errs, fb); end
        total++;
        if (busy_cyc_b - c0 !== 2306) begin
            bad++; $display("FAIL noskip_busy_cycles: got %0d expected 2306", busy_cyc_b - c0);
        end
    endtask

    task automatic test_empty_skip();
        int base, c0;
        bit to;
        logic [31:0] w;
        clear_mem();
        ts = 18'h3FFFF;
        base = got_a.size();
        c0   = busy_cyc_a;
        start_frame(1'b0);
        wait_idle(1'b0, 5000, to);
        total++;
        if (to || got_a.size() - base !== 2) begin
            bad++; $display("FAIL skip_count: got %0d timeout=%b expected 2", got_a.size() - base, to);
        end
        w = got_a[base];
        total++;
        if (w !== 32'hA503FFFF) begin bad++; $display("FAIL skip_header: got %h expected a503ffff", w); end
        w = got_a[base + 1];
        total++;
        if (w !== 32'h5A000000) begin bad++; $display("FAIL skip_trailer: got %h expected 5a000000", w); end
        total++;
        if (busy_cyc_a - c0 !== 770) begin
            bad++; $display("FAIL skip_busy_cycles: got %0d expected 770", busy_cyc_a - c0);
        end
    endtask

    task automatic test_backpressure();
        int base, sv0, errs, fb, n;
        set_sparse_mem();
        mem[1]   = mk_rec(14'd2, 16'h0F0F, 26'h1111111, 16'hF0F0, 26'h2222222,
                          16'h1234, 26'h3333333, 9'h0C3, 9'h13C);
        mem[100] = mk_rec(14'h1000, 16'hDEAD, 26'h0BEEF00, 16'hCAFE, 26'h0F00D00,
                          16'hBABE, 26'h1ACE000, 9'h1A5, 9'h05A);
        ts = 18'h15555;
        build_exp(1'b1, ts);
        base = got_a.size();
        sv0  = stab_viol;
        start_frame(1'b0);
        n = 0;
        while (busy_a && n < 20000) begin
            @(posedge clk); #1;
            dout_ready = ($urandom_range(0, 99) < 30);
            n++;
        end
        dout_ready = 1'b1;
        total++;
        if (busy_a) begin bad++; $display("FAIL bp_timeout: busy %b expected 0", busy_a); end
        total++;
        if (got_a.size() - base !== exp_q.size()) begin
            bad++; $display("FAIL bp_count: got %0d expected %0d", got_a.size() - base, exp_q.size());
        end
        errs = frame_errors(1'b0, base, fb);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL bp_stream: got %0d bad words (first %0d) expected 0", errs, fb); end
        total++;
        if (stab_viol - sv0 !== 0) begin
            bad++; $display("FAIL bp_hold_stable: got %0d changes while stalled expected 0", stab_viol - sv0);
        end
    endtask

    task automatic test_overrun();
        int base, errs, fb;
        bit to;
        set_sparse_mem();
        ts = 18'h00777;
        build_exp(1'b1, ts);
        total++;
        if (ovr_a !== 8'd0) begin bad++; $display("FAIL ovr_initial: got %0d expected 0", ovr_a); end
        base = got_a.size();
        start_frame(1'b0);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1 snap_a = 1'b1;
            @(posedge clk); #1 snap_a = 1'b0;
        end
        wait_idle(1'b0, 5000, to);
        total++;
        if (ovr_a !== 8'd255) begin bad++; $display("FAIL ovr_saturate: got %0d expected 255", ovr_a); end
        errs = frame_errors(1'b0, base, fb);
        total++;
        if (to || errs !== 0 || got_a.size() - base !== 20) begin
            bad++; $display("FAIL ovr_frame: got %0d bad words, %0d words, timeout=%b expected 0, 20, 0",
                            errs, got_a.size() - base, to);
        end
        base = got_a.size();
        start_frame(1'b0);
        wait_idle(1'b0, 5000, to);
        errs = frame_errors(1'b0, base, fb);
        total++;
        if (to || errs !== 0 || got_a.size() - base !== 20) begin
            bad++; $display("FAIL ovr_restart: got %0d bad words, %0d words, timeout=%b expected 0, 20, 0",
                            errs, got_a.size() - base, to);
        end
        total++;
        if (ovr_a !== 8'd255) begin bad++; $display("FAIL ovr_hold: got %0d expected 255", ovr_a); end
    endtask

    task automatic test_reset_mid_frame();
        int base, errs, fb, n;
        bit to;
        set_sparse_mem();
        mem[5] = mk_rec(14'd9, 16'h0505, 26'h0050505, 16'h5050, 26'h0505050,
                        16'h5A5A, 26'h0A5A5A5, 9'h005, 9'h050);
        ts = 18'h00005;
        start_frame(1'b0);
        n = 0;
        @(negedge clk);
        while (!(dbg_a == ST_EMIT && rd_addr_a == 8'd5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(dbg_a == ST_EMIT && rd_addr_a == 8'd5)) begin
            bad++; $display("FAIL rstmid_reach: state %0d addr %0d expected 5 and 5", dbg_a, rd_addr_a);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({valid_a, busy_a} !== 2'b00) begin
            bad++; $display("FAIL rstmid_abort: got valid=%b busy=%b expected 0 0", valid_a, busy_a);
        end
        total++;
        if (ovr_a !== 8'd0) begin bad++; $display("FAIL rstmid_ovr_clear: got %0d expected 0", ovr_a); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        build_exp(1'b1, ts);
        base = got_a.size();
        start_frame(1'b0);
        wait_idle(1'b0, 5000, to);
        total++;
        if (to || got_a.size() - base !== 26) begin
            bad++; $display("FAIL rstmid_count: got %0d timeout=%b expected 26", got_a.size() - base, to);
        end
        errs = frame_errors(1'b0, base, fb);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL rstmid_stream: got %0d bad words (first %0d) expected 0", errs, fb); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sparse();
        test_field_boundaries();
        test_empty_noskip();
        test_empty_skip();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
